ws2812_rx: RTL

WS2812_RX -- requirements
Module: ws2812_rx

---
 rtl/ws2812_rx_if.sv | 28 ++
 rtl/ws2812_rx.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/ws2812_rx_if.sv
// WS2812 receiver signal bundle: serial line in, decoded words and status pulses out.
// The slave modport is the receiver's view; master is the line driver / word consumer.
interface ws2812_rx_if;
    logic        din;
    logic [23:0] data;
    logic        valid;
    logic [7:0]  idx;
    logic        frame_end;
    logic        err;

    modport master (
        output din,
        input  data,
        input  valid,
        input  idx,
        input  frame_end,
        input  err
    );

    modport slave (
        input  din,
        output data,
        output valid,
        output idx,
        output frame_end,
        output err
    );
endinterface

// File: rtl/ws2812_rx.sv
// WS2812 serial decoder: measures high-pulse widths of a synchronized line,
// assembles 24-bit MSB-first words and flags frame gaps and protocol errors.
module ws2812_rx #(
    parameter int HI_MIN    = 10,
    parameter int HI_THRESH = 29,
    parameter int HI_MAX    = 60,
    parameter int RESET_CYC = 2400
) (
    input  logic        clk,
    input  logic        rst,
    ws2812_rx_if.slave  bus
);

    localparam int CW = $clog2(RESET_CYC + 1);
    localparam logic [CW-1:0] RC_C     = CW'(RESET_CYC);
    localparam logic [CW-1:0] RC_M1_C  = CW'(RESET_CYC - 1);
    localparam logic [CW-1:0] MIN_C    = CW'(HI_MIN);
    localparam logic [CW-1:0] THRESH_C = CW'(HI_THRESH);
    localparam logic [CW-1:0] MAX_M1_C = CW'(HI_MAX - 1);
    localparam logic [CW-1:0] ONE_C    = CW'(1);

    typedef enum logic [1:0] {SYNC, LOW, HIGH} state_t;

    logic [1:0]    sync_reg;
    state_t        state_reg, state_next;
    logic [CW-1:0] cnt_reg, cnt_next;
    logic [4:0]    bits_reg, bits_next;
    logic [7:0]    widx_reg, widx_next;
    logic [23:0]   shift_reg, shift_next;
    logic [23:0]   data_reg, data_next;
    logic [7:0]    idx_reg, idx_next;
    logic          valid_reg, valid_next;
    logic          fend_reg, fend_next;
    logic          err_reg, err_next;

    logic          din_s;
    logic [CW-1:0] cnt_inc;
    logic [23:0]   shift_in;

    assign din_s    = sync_reg[1];
    assign cnt_inc  = (cnt_reg == RC_C) ? cnt_reg : cnt_reg + ONE_C;
    assign shift_in = {shift_reg[22:0], (cnt_reg >= THRESH_C)};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_reg  <= 2'b00;
            state_reg <= SYNC;
            cnt_reg   <= '0;
            bits_reg  <= '0;
            widx_reg  <= '0;
            shift_reg <= '0;
            data_reg  <= '0;
            idx_reg   <= '0;
            valid_reg <= 1'b0;
            fend_reg  <= 1'b0;
            err_reg   <= 1'b0;
        end else begin
            sync_reg  <= {sync_reg[0], bus.din};
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            bits_reg  <= bits_next;
            widx_reg  <= widx_next;
            shift_reg <= shift_next;
            data_reg  <= data_next;
            idx_reg   <= idx_next;
            valid_reg <= valid_next;
            fend_reg  <= fend_next;
            err_reg   <= err_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        bits_next  = bits_reg;
        widx_next  = widx_reg;
        shift_next = shift_reg;
        data_next  = data_reg;
        idx_next   = idx_reg;
        valid_next = 1'b0;
        fend_next  = 1'b0;
        err_next   = 1'b0;

        unique case (state_reg)
            SYNC: begin
                if (din_s) begin
                    cnt_next = '0;
                end else if (cnt_inc == RC_C) begin
                    state_next = LOW;
                    cnt_next   = '0;
                    bits_next  = '0;
                    widx_next  = '0;
                end else begin
                    cnt_next = cnt_inc;
                end
            end

            LOW: begin
                if (din_s) begin
                    state_next = HIGH;
                    cnt_next   = ONE_C;
                end else begin
                    cnt_next = cnt_inc;
                    // Gap fires once: the counter then sits saturated at RESET_CYC.
                    if (cnt_reg == RC_M1_C) begin
                        if (bits_reg == 5'd0) begin
                            fend_next = (widx_reg != 8'd0);
                        end else begin
                            err_next = 1'b1;
                        end
                        bits_next = '0;
                        widx_next = '0;
                    end
                end
            end

            HIGH: begin
                if (din_s) begin
                    if (cnt_reg >= MAX_M1_C) begin
                        err_next   = 1'b1;
                        state_next = SYNC;
                        cnt_next   = '0;
                        bits_next  = '0;
                    end else begin
                        cnt_next = cnt_reg + ONE_C;
                    end
                end else if (cnt_reg < MIN_C) begin
                    // The current low cycle already counts towards the resync gap.
                    err_next   = 1'b1;
                    state_next = SYNC;
                    cnt_next   = ONE_C;
                    bits_next  = '0;
                end else begin
                    shift_next = shift_in;
                    state_next = LOW;
                    cnt_next   = ONE_C;
                    if (bits_reg == 5'd23) begin
                        data_next  = shift_in;
                        valid_next = 1'b1;
                        idx_next   = widx_reg;
                        widx_next  = (widx_reg == 8'hFF) ? widx_reg : widx_reg + 8'd1;
                        bits_next  = '0;
                    end else begin
                        bits_next = bits_reg + 5'd1;
                    end
                end
            end

            default: begin
                state_next = SYNC;
                cnt_next   = '0;
            end
        endcase
    end

    assign bus.data      = data_reg;
    assign bus.valid     = valid_reg;
    assign bus.idx       = idx_reg;
    assign bus.frame_end = fend_reg;
    assign bus.err       = err_reg;

endmodule
